// File: rtl/regfile_seq_pkg.sv
// Shared types and widths for the LC-3 register-file write sequencer.
package regfile_seq_pkg;

  localparam int REG_W = 16;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } seq_state_t;

  typedef struct packed {
    logic [SEL_W-1:0] dr;
    logic [REG_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_sequencer_arb2_rr.sv
// Two-input arbiter for the register-file write port.
// Default build: round-robin with a one-bit preference pointer that moves to
// the non-granted requester whenever grant_en is high.
// REGFILE_SEQ_FIXED_PRIO_EN defined: requester 0 always wins, no pointer.
module arb2_rr (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       grant_id
);

`ifdef REGFILE_SEQ_FIXED_PRIO_EN
  // Clock, reset, enable and req[1] carry no information in fixed priority.
  logic unused_fixed_prio;
  assign unused_fixed_prio = Clk ^ Reset ^ grant_en ^ req[1];

  // Requester 1 only wins when requester 0 is silent.
  assign grant_id = ~req[0];
`else
  logic ptr;

  // Lone requester wins outright; on a tie the pointer decides.
  always_comb begin
    grant_id = ptr;
    if (req == 2'b01)      grant_id = 1'b0;
    else if (req == 2'b10) grant_id = 1'b1;
  end

  // After each grant, prefer the requester that just lost (or was idle).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)         ptr <= 1'b0;
    else if (grant_en) ptr <= ~grant_id;
  end
`endif

endmodule

// File: rtl/regfile_write_sequencer.sv
// Sequences writes from two requesters onto the LC-3 register file's single
// write port. DR/D_in are captured at the grant and held; LD_REG is a
// registered one-cycle strobe with a full cycle of setup and hold on each side.
// Arbitration policy is selected by REGFILE_SEQ_FIXED_PRIO_EN (see arb2_rr).
module regfile_write_sequencer
  import regfile_seq_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       wr_valid,
  input  logic [SEL_W-1:0] wr_dr0,
  input  logic [SEL_W-1:0] wr_dr1,
  input  logic [REG_W-1:0] wr_data0,
  input  logic [REG_W-1:0] wr_data1,
  output logic [1:0]       wr_ready,
  output logic [SEL_W-1:0] DR,
  output logic [REG_W-1:0] D_in,
  output logic             LD_REG,
  output logic             busy,
  output logic             grant_id
);

  seq_state_t state, next_state;
  logic       grant_en;
  logic       arb_id;
  wr_req_t    req0, req1, win_req;

  assign req0     = '{dr: wr_dr0, data: wr_data0};
  assign req1     = '{dr: wr_dr1, data: wr_data1};
  assign win_req  = arb_id ? req1 : req0;
  assign grant_en = (state == IDLE) && (|wr_valid);
  assign busy     = (state != IDLE);

  arb2_rr u_arb (
    .Clk      (Clk),
    .Reset    (Reset),
    .req      (wr_valid),
    .grant_en (grant_en),
    .grant_id (arb_id)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: one cycle each in SETUP, STROBE and HOLD.
  always_comb begin
    // NOTE: default assigned first so no path leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      IDLE:   if (|wr_valid) next_state = SETUP;
      SETUP:  next_state = STROBE;
      STROBE: next_state = HOLD;
      HOLD:   next_state = IDLE;
    endcase
  end

  // Registered outputs: capture winner at grant, strobe in STROBE, ack in HOLD.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DR       <= '0;
      D_in     <= '0;
      grant_id <= 1'b0;
      LD_REG   <= 1'b0;
      wr_ready <= 2'b00;
    end else begin
      LD_REG   <= (state == SETUP);
      wr_ready <= 2'b00;
      if (state == STROBE) wr_ready[grant_id] <= 1'b1;
      if (grant_en) begin
        DR       <= win_req.dr;
        D_in     <= win_req.data;
        grant_id <= arb_id;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Self-checking bench for regfile_write_sequencer: table-driven transactions,
// hand-written multi-cycle sequences, and randomized traffic against a
// transaction-level reference model.
module tb_regfile_write_sequencer;
  import regfile_seq_pkg::*;

`ifdef REGFILE_SEQ_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Reset;
  logic [1:0]       wr_valid;
  logic [SEL_W-1:0] wr_dr0, wr_dr1;
  logic [REG_W-1:0] wr_data0, wr_data1;
  logic [1:0]       wr_ready;
  logic [SEL_W-1:0] DR;
  logic [REG_W-1:0] D_in;
  logic             LD_REG, busy, grant_id;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  regfile_write_sequencer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .wr_valid (wr_valid),
    .wr_dr0   (wr_dr0),
    .wr_dr1   (wr_dr1),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .wr_ready (wr_ready),
    .DR       (DR),
    .D_in     (D_in),
    .LD_REG   (LD_REG),
    .busy     (busy),
    .grant_id (grant_id)
  );

  typedef struct {
    logic [1:0]       v;
    logic [SEL_W-1:0] dr0;
    logic [REG_W-1:0] d0;
    logic [SEL_W-1:0] dr1;
    logic [REG_W-1:0] d1;
    logic             mutate;
    logic             exp_gid;
    logic [SEL_W-1:0] exp_dr;
    logic [REG_W-1:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [SEL_W-1:0] dr0,
                              input logic [REG_W-1:0] d0, input logic [SEL_W-1:0] dr1,
                              input logic [REG_W-1:0] d1, input logic mutate,
                              input logic gid);
    vec_t t;
    t.v = v; t.dr0 = dr0; t.d0 = d0; t.dr1 = dr1; t.d1 = d1; t.mutate = mutate;
    t.exp_gid  = gid;
    t.exp_dr   = gid ? dr1 : dr0;
    t.exp_data = gid ? d1 : d0;
    return t;
  endfunction

  // Holds reset over two edges; returns just after a falling edge.
  task automatic do_reset();
    Reset    = 1'b1;
    wr_valid = 2'b00;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // One complete write from IDLE; starts and ends just after a falling edge.
  task automatic run_txn(input int idx, input vec_t t);
    wr_valid = t.v;
    wr_dr0 = t.dr0; wr_data0 = t.d0;
    wr_dr1 = t.dr1; wr_data1 = t.d1;
    @(posedge Clk); @(negedge Clk);  // SETUP
    check($sformatf("t%0d setup busy", idx), 32'(busy), 32'd1);
    check($sformatf("t%0d setup ld", idx), 32'(LD_REG), 32'd0);
    check($sformatf("t%0d setup gid", idx), 32'(grant_id), 32'(t.exp_gid));
    check($sformatf("t%0d setup dr", idx), 32'(DR), 32'(t.exp_dr));
    check($sformatf("t%0d setup din", idx), 32'(D_in), 32'(t.exp_data));
    if (t.mutate) begin
      wr_data1 = 16'h5555;
      wr_dr1   = ~t.dr1;
      wr_data0 = 16'h5555;
    end
    @(posedge Clk); @(negedge Clk);  // STROBE
    check($sformatf("t%0d strobe ld", idx), 32'(LD_REG), 32'd1);
    check($sformatf("t%0d strobe rdy", idx), 32'(wr_ready), 32'd0);
    check($sformatf("t%0d strobe dr", idx), 32'(DR), 32'(t.exp_dr));
    check($sformatf("t%0d strobe din", idx), 32'(D_in), 32'(t.exp_data));
    @(posedge Clk); @(negedge Clk);  // HOLD
    check($sformatf("t%0d hold ld", idx), 32'(LD_REG), 32'd0);
    check($sformatf("t%0d hold rdy", idx), 32'(wr_ready), 32'(2'b01 << t.exp_gid));
    check($sformatf("t%0d hold dr", idx), 32'(DR), 32'(t.exp_dr));
    check($sformatf("t%0d hold din", idx), 32'(D_in), 32'(t.exp_data));
    wr_valid = 2'b00;
    @(posedge Clk); @(negedge Clk);  // IDLE
    check($sformatf("t%0d idle busy", idx), 32'(busy), 32'd0);
    check($sformatf("t%0d idle rdy", idx), 32'(wr_ready), 32'd0);
    check($sformatf("t%0d idle din", idx), 32'(D_in), 32'(t.exp_data));
  endtask

  initial begin
    vec_t tbl[8];
    wr_dr0 = '0; wr_dr1 = '0; wr_data0 = '0; wr_data1 = '0;
    do_reset();

    // Reset state.
    check("rst dr", 32'(DR), 32'd0);
    check("rst din", 32'(D_in), 32'd0);
    check("rst ld", 32'(LD_REG), 32'd0);
    check("rst rdy", 32'(wr_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst gid", 32'(grant_id), 32'd0);

    // Transactions in order from reset; the round-robin pointer carries across.
    tbl[0] = mk(2'b01, 3'd3, 16'hBEEF, 3'd0, 16'h0000, 1'b0, 1'b0);
    tbl[1] = mk(2'b11, 3'd1, 16'h1111, 3'd2, 16'h2222, 1'b0, FIXED ? 1'b0 : 1'b1);
    tbl[2] = mk(2'b11, 3'd1, 16'h1111, 3'd2, 16'h2222, 1'b0, 1'b0);
    tbl[3] = mk(2'b10, 3'd0, 16'h0000, 3'd5, 16'h1234, 1'b0, 1'b1);
    tbl[4] = mk(2'b10, 3'd0, 16'h0000, 3'd4, 16'hAAAA, 1'b1, 1'b1);
    tbl[5] = mk(2'b11, 3'd6, 16'h0F0F, 3'd7, 16'hF0F0, 1'b0, 1'b0);
    tbl[6] = mk(2'b11, 3'd0, 16'hFFFF, 3'd1, 16'h0000, 1'b0, FIXED ? 1'b0 : 1'b1);
    tbl[7] = mk(2'b01, 3'd2, 16'h0000, 3'd6, 16'h9999, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) run_txn(i, tbl[i]);

    // Both requesters continuously valid: grants alternate (or r0 starves r1).
    do_reset();
    wr_valid = 2'b11;
    wr_dr0 = 3'd1; wr_data0 = 16'h1111;
    wr_dr1 = 3'd2; wr_data1 = 16'h2222;
    for (int g = 0; g < 4; g++) begin
      logic exp_g;
      exp_g = FIXED ? 1'b0 : logic'(g % 2);
      @(posedge Clk); @(negedge Clk);
      check($sformatf("alt grant%0d gid", g), 32'(grant_id), 32'(exp_g));
      check($sformatf("alt grant%0d dr", g), 32'(DR), exp_g ? 32'd2 : 32'd1);
      repeat (3) begin @(posedge Clk); @(negedge Clk); end
    end
    wr_valid = 2'b00;
    @(posedge Clk); @(negedge Clk);

    // Reset asserted during STROBE: everything clears at once, no ready.
    do_reset();
    wr_valid = 2'b01; wr_dr0 = 3'd6; wr_data0 = 16'h7777;
    @(posedge Clk); @(negedge Clk);
    @(posedge Clk); @(negedge Clk);
    check("mid strobe ld", 32'(LD_REG), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("mid rst ld", 32'(LD_REG), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst dr", 32'(DR), 32'd0);
    check("mid rst din", 32'(D_in), 32'd0);
    check("mid rst rdy", 32'(wr_ready), 32'd0);
    @(posedge Clk); @(negedge Clk);
    check("mid rst held rdy", 32'(wr_ready), 32'd0);
    Reset = 1'b0;
    run_txn(100, mk(2'b01, 3'd6, 16'h7777, 3'd0, 16'h0000, 1'b0, 1'b0));

    // Back-to-back writes to R7: two strobes four cycles apart, r1's data last.
    do_reset();
    begin
      int   pulses[$];
      int   consec;
      int   gap;
      logic prev_ld;
      logic [REG_W-1:0] last_din;
      consec = 0; prev_ld = 1'b0; last_din = '0;
      wr_valid = 2'b11;
      wr_dr0 = 3'd7; wr_data0 = 16'h0001;
      wr_dr1 = 3'd7; wr_data1 = 16'h0002;
      for (int c = 0; c < 12; c++) begin
        @(posedge Clk); @(negedge Clk);
        if (LD_REG) begin
          pulses.push_back(c);
          last_din = D_in;
        end
        if (LD_REG && prev_ld) consec++;
        prev_ld  = LD_REG;
        wr_valid = wr_valid & ~wr_ready;
      end
      gap = (pulses.size() == 2) ? pulses[1] - pulses[0] : -1;
      check("b2b pulse count", 32'(pulses.size()), 32'd2);
      check("b2b pulse gap", 32'(gap), 32'd4);
      check("b2b no double ld", 32'(consec), 32'd0);
      check("b2b final din", 32'(last_din), 32'h0002);
      check("b2b final dr", 32'(DR), 32'd7);
    end

    // Randomized traffic against a transaction-level model.
    do_reset();
    begin
      int   m_phase;   // cycles elapsed since the current grant, 0 when idle
      logic m_pref;
      logic m_gid;
      logic w;
      logic [SEL_W-1:0] m_dr;
      logic [REG_W-1:0] m_data;
      logic [1:0] exp_rdy;
      m_phase = 0; m_pref = 1'b0; m_gid = 1'b0; m_dr = '0; m_data = '0;
      wr_valid = 2'b00;
      for (int c = 0; c < 400; c++) begin
        exp_rdy = (m_phase == 3) ? (2'b01 << m_gid) : 2'b00;
        check($sformatf("rnd c%0d busy", c), 32'(busy), 32'(m_phase != 0));
        check($sformatf("rnd c%0d ld", c), 32'(LD_REG), 32'(m_phase == 2));
        check($sformatf("rnd c%0d rdy", c), 32'(wr_ready), 32'(exp_rdy));
        check($sformatf("rnd c%0d dr", c), 32'(DR), 32'(m_dr));
        check($sformatf("rnd c%0d din", c), 32'(D_in), 32'(m_data));
        if (m_phase != 0)
          check($sformatf("rnd c%0d gid", c), 32'(grant_id), 32'(m_gid));
        // Requesters: retire on ready, then maybe raise a new request.
        if (wr_valid[0] && exp_rdy[0]) wr_valid[0] = 1'b0;
        if (wr_valid[1] && exp_rdy[1]) wr_valid[1] = 1'b0;
        if (!wr_valid[0] && $urandom_range(0, 2) == 0) begin
          wr_valid[0] = 1'b1;
          wr_dr0   = SEL_W'($urandom);
          wr_data0 = REG_W'($urandom);
        end
        if (!wr_valid[1] && $urandom_range(0, 2) == 0) begin
          wr_valid[1] = 1'b1;
          wr_dr1   = SEL_W'($urandom);
          wr_data1 = REG_W'($urandom);
        end
        @(posedge Clk);
        if (m_phase == 0) begin
          if (wr_valid != 2'b00) begin
            if (wr_valid == 2'b11) w = FIXED ? 1'b0 : m_pref;
            else                   w = wr_valid[1];
            m_pref  = ~w;
            m_gid   = w;
            m_dr    = w ? wr_dr1 : wr_dr0;
            m_data  = w ? wr_data1 : wr_data0;
            m_phase = 1;
          end
        end else begin
          m_phase = (m_phase + 1) % 4;
        end
        @(negedge Clk);
      end
      wr_valid = 2'b00;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
